fetch_decode_execute: RTL and testbench

FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

---
 rtl/fetch_decode_execute.sv | 183 ++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_execute.sv
// fetch_decode_execute: RV32I decode/execute stage with registered instruction, pc and regfile reads.
// Optional RF_WRITE_BYPASS_EN: a same-edge regfile read returns wb_data instead of the old contents.
`default_nettype none

module fetch_decode_execute (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [1:0]  fwd_rs1,
  input  logic [1:0]  fwd_rs2,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
  output logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic [31:0] addr_out,
  output logic [31:0] store_data,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [2:0]  funct3,
  output logic        mem_w,
  output logic        reg_w,
  output logic        mem2reg,
  output logic        bra,
  output logic        jmp
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] regs [1:31];
  logic [31:0] instr_q, pc_q, rs1_q, rs2_q;
  logic [4:0]  rd_a1, rd_a2;
  logic [31:0] rd_d1, rd_d2;

  // While stalled, re-read with the held instruction so late writebacks are picked up.
  assign rd_a1 = stall ? instr_q[19:15] : instr[19:15];
  assign rd_a2 = stall ? instr_q[24:20] : instr[24:20];

  always_comb begin
    rd_d1 = (rd_a1 == 5'd0) ? 32'd0 : regs[rd_a1];
    rd_d2 = (rd_a2 == 5'd0) ? 32'd0 : regs[rd_a2];
`ifdef RF_WRITE_BYPASS_EN
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rd_a1)) rd_d1 = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rd_a2)) rd_d2 = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (wb_we && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
    end else if (flush) begin
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
    end else begin
      if (!stall) begin
        instr_q <= instr;
        pc_q    <= pc;
      end
      rs1_q <= rd_d1;
      rs2_q <= rd_d2;
    end
  end

  logic [6:0]  opcode;
  logic        is_op, alt;
  logic [31:0] op_a, op_rs2, op_b, alu_res;
  logic        taken;

  assign opcode   = instr_q[6:0];
  assign rd_addr  = instr_q[11:7];
  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];
  assign funct3   = instr_q[14:12];
  assign alt      = instr_q[30];
  assign is_op    = (opcode == OPC_OP);

  always_comb begin
    case (fwd_rs1)
      2'b01:   op_a = mem_fwd;
      2'b10:   op_a = wb_fwd;
      default: op_a = rs1_q;
    endcase
    case (fwd_rs2)
      2'b01:   op_rs2 = mem_fwd;
      2'b10:   op_rs2 = wb_fwd;
      default: op_rs2 = rs2_q;
    endcase
  end

  assign store_data = op_rs2;

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm = {instr_q[31:12], 12'd0};
      OPC_JAL:  imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{instr_q[31]}}, instr_q[31:20]};
      OPC_STORE:  imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OPC_BRANCH: imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      default:  imm = 32'd0;
    endcase
  end

  assign op_b = is_op ? op_rs2 : imm;

  always_comb begin
    case (funct3)
      3'b000:  alu_res = (is_op && alt) ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_res = op_a << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, op_a < op_b};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = alt ? 32'($signed(op_a) >>> op_b[4:0]) : (op_a >> op_b[4:0]);
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = (op_a == op_rs2);
      3'b001:  taken = (op_a != op_rs2);
      3'b100:  taken = $signed(op_a) < $signed(op_rs2);
      3'b101:  taken = $signed(op_a) >= $signed(op_rs2);
      3'b110:  taken = op_a < op_rs2;
      3'b111:  taken = op_a >= op_rs2;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_out = 32'd0;
    mem_w   = 1'b0;
    reg_w   = 1'b0;
    mem2reg = 1'b0;
    bra     = 1'b0;
    jmp     = 1'b0;
    case (opcode)
      OPC_LUI:    begin alu_out = imm;          reg_w = 1'b1; end
      OPC_AUIPC:  begin alu_out = pc_q + imm;   reg_w = 1'b1; end
      OPC_JAL,
      OPC_JALR:   begin alu_out = pc_q + 32'd4; reg_w = 1'b1; jmp = 1'b1; end
      OPC_BRANCH: begin alu_out = {31'd0, taken}; bra = 1'b1; end
      OPC_LOAD:   begin alu_out = op_a + imm;   reg_w = 1'b1; mem2reg = 1'b1; end
      OPC_STORE:  begin alu_out = op_a + imm;   mem_w = 1'b1; end
      OPC_OPIMM,
      OPC_OP:     begin alu_out = alu_res;      reg_w = 1'b1; end
      default:    alu_out = 32'd0;
    endcase
    // x0 destinations never write back.
    if (rd_addr == 5'd0) reg_w = 1'b0;
  end

  logic [31:0] jalr_sum;
  assign jalr_sum = op_a + imm;
  assign addr_out = (opcode == OPC_JALR) ? {jalr_sum[31:1], 1'b0} : (pc_q + imm);

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_execute.sv
// Directed table-driven bench for fetch_decode_execute plus hand sequences for stall/flush/reset/bypass.
`default_nettype none

module tb_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic        stall, flush, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, mem_fwd, wb_fwd;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [31:0] imm, alu_out, addr_out, store_data;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [2:0]  funct3;
  logic        mem_w, reg_w, mem2reg, bra, jmp;

  int tests = 0;
  int failed = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  fetch_decode_execute dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .imm(imm), .alu_out(alu_out), .addr_out(addr_out), .store_data(store_data),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct3(funct3),
    .mem_w(mem_w), .reg_w(reg_w), .mem2reg(mem2reg), .bra(bra), .jmp(jmp)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] mfwd;
    logic [31:0] wfwd;
    logic [31:0] e_alu;
    logic [31:0] e_imm;
    logic [31:0] e_addr;
    logic [4:0]  e_ctl;  // {mem_w, reg_w, mem2reg, bra, jmp}
  } vec_t;

  vec_t vecs [18];

  function automatic logic [31:0] ctl_word();
    return {27'd0, mem_w, reg_w, mem2reg, bra, jmp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop(input string name);
    chk({name, " alu"}, alu_out, 32'd0);
    chk({name, " imm"}, imm, 32'd0);
    chk({name, " addr"}, addr_out, 32'd0);
    chk({name, " ctl"}, ctl_word(), 32'd0);
    chk({name, " sd"}, store_data, 32'd0);
    chk({name, " fields"}, {14'd0, rd_addr, rs1_addr, rs2_addr, funct3}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h00328313, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'h13,       32'h3,        32'h3,        5'b01000}; // ADDI x6,x5,3
    vecs[1]  = '{32'h00000463, 32'h100, 2'b00, 2'b00, 32'h0, 32'h0,  32'h1,        32'h8,        32'h108,      5'b00010}; // BEQ x0,x0,+8
    vecs[2]  = '{32'h005100E7, 32'h40,  2'b00, 2'b00, 32'h0, 32'h0,  32'h44,       32'h5,        32'h1004,     5'b01001}; // JALR x1,5(x2)
    vecs[3]  = '{32'h008081B3, 32'h200, 2'b01, 2'b00, 32'h7, 32'h0,  32'h9,        32'h0,        32'h200,      5'b01000}; // ADD, rs1 fwd mem
    vecs[4]  = '{32'h40828233, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'hE,        32'h0,        32'h0,        5'b01000}; // SUB
    vecs[5]  = '{32'h4024D593, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'hFFFFFFFC, 32'h402,      32'h402,      5'b01000}; // SRAI
    vecs[6]  = '{32'h00943633, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'h1,        32'h0,        32'h0,        5'b01000}; // SLTU
    vecs[7]  = '{32'h00942633, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'h0,        32'h0,        32'h0,        5'b01000}; // SLT
    vecs[8]  = '{32'hFFC12683, 32'h10,  2'b00, 2'b00, 32'h0, 32'h0,  32'hFFC,      32'hFFFFFFFC, 32'hC,        5'b01100}; // LW
    vecs[9]  = '{32'h00812423, 32'h0,   2'b00, 2'b10, 32'h0, 32'h55, 32'h1008,     32'h8,        32'h8,        5'b10000}; // SW, rs2 fwd wb
    vecs[10] = '{32'hFE84CEE3, 32'h80,  2'b00, 2'b00, 32'h0, 32'h0,  32'h1,        32'hFFFFFFFC, 32'h7C,       5'b00010}; // BLT
    vecs[11] = '{32'hFE84EEE3, 32'h80,  2'b00, 2'b00, 32'h0, 32'h0,  32'h0,        32'hFFFFFFFC, 32'h7C,       5'b00010}; // BLTU
    vecs[12] = '{32'hFE84AEE3, 32'h80,  2'b00, 2'b00, 32'h0, 32'h0,  32'h0,        32'hFFFFFFFC, 32'h7C,       5'b00010}; // funct3 010
    vecs[13] = '{32'h12345737, 32'h0,   2'b00, 2'b00, 32'h0, 32'h0,  32'h12345000, 32'h12345000, 32'h12345000, 5'b01000}; // LUI
    vecs[14] = '{32'h00001797, 32'h100, 2'b00, 2'b00, 32'h0, 32'h0,  32'h1100,     32'h1000,     32'h1100,     5'b01000}; // AUIPC
    vecs[15] = '{32'h0100006F, 32'h20,  2'b00, 2'b00, 32'h0, 32'h0,  32'h24,       32'h10,       32'h30,       5'b00001}; // JAL x0
    vecs[16] = '{32'h0000007F, 32'h50,  2'b00, 2'b00, 32'h0, 32'h0,  32'h0,        32'h0,        32'h50,       5'b00000}; // bad opcode
    vecs[17] = '{32'hFFF46313, 32'h10,  2'b00, 2'b00, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF,        5'b01000}; // ORI -1

    for (int i = 0; i < 32; i++) model[i] = 32'h11 * i;
    model[0] = 32'h0;
    model[2] = 32'h1000;
    model[5] = 32'h10;
    model[8] = 32'h2;
    model[9] = 32'hFFFFFFF0;

    rst = 1'b0; instr = 32'h00328313; pc = 32'h44; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    fwd_rs1 = 2'b00; fwd_rs2 = 2'b00; mem_fwd = 32'd0; wb_fwd = 32'd0;
    step();
    step();
    chk_nop("reset");
    rst = 1'b1;
    instr = 32'h0;
    pc = 32'h0;

    for (int r = 1; r < 32; r++) begin
      wb_we = 1'b1; wb_addr = 5'(r); wb_data = model[r];
      step();
    end
    wb_we = 1'b0;

    for (int i = 0; i < 18; i++) begin
      logic [31:0] e_sd;
      instr = vecs[i].instr; pc = vecs[i].pc;
      fwd_rs1 = vecs[i].f1; fwd_rs2 = vecs[i].f2;
      mem_fwd = vecs[i].mfwd; wb_fwd = vecs[i].wfwd;
      step();
      e_sd = (vecs[i].f2 == 2'b01) ? vecs[i].mfwd :
             (vecs[i].f2 == 2'b10) ? vecs[i].wfwd : model[vecs[i].instr[24:20]];
      chk($sformatf("v%0d alu", i), alu_out, vecs[i].e_alu);
      chk($sformatf("v%0d imm", i), imm, vecs[i].e_imm);
      chk($sformatf("v%0d addr", i), addr_out, vecs[i].e_addr);
      chk($sformatf("v%0d ctl", i), ctl_word(), {27'd0, vecs[i].e_ctl});
      chk($sformatf("v%0d sd", i), store_data, e_sd);
      chk($sformatf("v%0d fields", i), {14'd0, rd_addr, rs1_addr, rs2_addr, funct3},
          {14'd0, vecs[i].instr[11:7], vecs[i].instr[19:15], vecs[i].instr[24:20], vecs[i].instr[14:12]});
    end
    fwd_rs1 = 2'b00; fwd_rs2 = 2'b00; mem_fwd = 32'd0; wb_fwd = 32'd0;

    // Stall: outputs must hold while new instructions are presented.
    instr = 32'h00328313; pc = 32'h0;
    step();
    chk("pre-stall alu", alu_out, 32'h13);
    stall = 1'b1; instr = 32'h12345737; pc = 32'h999;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d alu", c), alu_out, 32'h13);
      chk($sformatf("stall%0d imm", c), imm, 32'h3);
      chk($sformatf("stall%0d rd", c), {27'd0, rd_addr}, 32'd6);
    end
    stall = 1'b0;
    step();
    chk("post-stall alu", alu_out, 32'h12345000);
    chk("post-stall addr", addr_out, 32'h12345999);

    // Flush beats stall.
    flush = 1'b1; stall = 1'b1; instr = 32'h00328313; pc = 32'h80;
    step();
    chk_nop("flush");
    flush = 1'b0; stall = 1'b0;

    // x0 write is discarded.
    instr = 32'h00100313; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    step();
    wb_we = 1'b0;
    step();
    chk("x0 addi", alu_out, 32'h1);

    // Same-edge write and read of x7.
    instr = 32'h00038813; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
    step();
`ifdef RF_WRITE_BYPASS_EN
    chk("bypass same edge", alu_out, 32'hAA);
`else
    chk("bypass same edge", alu_out, model[7]);
`endif
    wb_we = 1'b0;
    model[7] = 32'hAA;
    step();
    chk("bypass next edge", alu_out, 32'hAA);

    // Asynchronous reset clears outputs between edges; regfile survives.
    instr = 32'h00328313; pc = 32'h30;
    step();
    chk("pre-rst alu", alu_out, 32'h13);
    #2;
    rst = 1'b0;
    #1;
    chk_nop("async rst");
    rst = 1'b1;
    step();
    chk("post-rst alu", alu_out, 32'h13);
    chk("post-rst addr", addr_out, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
